// File: rtl/pc_ras_unit.sv
// pc_ras_unit
//   Fetch-stage program counter. It selects the next PC (sequential,
//   branch, jump, jal or jr), holds on a stall and takes a late-stage
//   redirect. A circular return-address stack (RAS) records jal return
//   addresses and predicts jr $31 targets. The prediction is reported only
//   through ras_miss. The jr target always comes from jr_addr.
//
//   Parameters
//     WORD_W     datapath/address width, >= 32
//     PC_INIT    imemaddr value after reset
//     RAS_DEPTH  RAS entries, power of 2, >= 2
//
//   Ports
//     CLK, RST       clock; synchronous active-high reset
//     pc_wait        stall: hold PC, RAS and ras_miss
//     pc_src         0 SEQ, 1 BRANCH, 2 JUMP, 3 JAL, 4 JR, 5-7 SEQ
//     load_addr      26-bit jump/jal target field
//     load_imm       16-bit signed word offset for branches
//     jr_addr        resolved jr register value
//     jr_is_ra       jr uses $31: pop the RAS and check the prediction
//     redirect       late-stage redirect to redirect_addr (beats pc_wait)
//     imemaddr       registered current PC
//     pc_plus4       imemaddr + 4
//     ras_top        top RAS entry, 0 when empty
//     ras_empty      RAS holds no entries
//     ras_full       RAS holds RAS_DEPTH entries
//     ras_miss       one-cycle pulse: the last jr $31 prediction was wrong
//     misalign       sticky misaligned-target fault
//
//   Build option
//     PC_MISALIGN_CHK_EN: when this macro is defined, a redirect or jr
//     target with nonzero [1:0] is refused. The PC and RAS hold, and
//     misalign sets and stays set until RST. When the macro is not defined,
//     targets load as they are and misalign is tied to 0.

module pc_ras_unit #(
    parameter int          WORD_W    = 32,
    parameter logic [WORD_W-1:0] PC_INIT = '0,
    parameter int          RAS_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              pc_wait,
    input  logic [2:0]        pc_src,
    input  logic [25:0]       load_addr,
    input  logic [15:0]       load_imm,
    input  logic [WORD_W-1:0] jr_addr,
    input  logic              jr_is_ra,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_addr,
    output logic [WORD_W-1:0] imemaddr,
    output logic [WORD_W-1:0] pc_plus4,
    output logic [WORD_W-1:0] ras_top,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ras_miss,
    output logic              misalign
);

    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    localparam logic [2:0] SRC_BRANCH = 3'd1;
    localparam logic [2:0] SRC_JUMP   = 3'd2;
    localparam logic [2:0] SRC_JAL    = 3'd3;
    localparam logic [2:0] SRC_JR     = 3'd4;

    logic [WORD_W-1:0] pc_q;
    logic [WORD_W-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              miss_q;

    logic [WORD_W-1:0] branch_off;
    logic [WORD_W-1:0] jump_tgt;
    logic [PTR_W-1:0]  ptr_inc;
    logic [PTR_W-1:0]  ptr_dec;
    logic              bad_redirect;
    logic              bad_jr;

    logic [WORD_W-1:0] pc_d;
    logic              miss_d;
    logic              push;
    logic              pop;
    logic              misalign_set;

    assign imemaddr  = pc_q;
    assign pc_plus4  = pc_q + WORD_W'(4);
    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == CNT_W'(RAS_DEPTH));
    assign ras_top   = ras_empty ? '0 : ras_mem[ptr_q];
    assign ras_miss  = miss_q;

    // The branch offset counts words. It is sign-extended and then scaled to bytes.
    assign branch_off = {{(WORD_W-18){load_imm[15]}}, load_imm, 2'b00};
    assign jump_tgt   = {pc_plus4[WORD_W-1:28], load_addr, 2'b00};

    // The depth is a power of two, so the pointer wraps without extra logic.
    assign ptr_inc = ptr_q + PTR_W'(1);
    assign ptr_dec = ptr_q - PTR_W'(1);

`ifdef PC_MISALIGN_CHK_EN
    assign bad_redirect = |redirect_addr[1:0];
    assign bad_jr       = |jr_addr[1:0];
`else
    assign bad_redirect = 1'b0;
    assign bad_jr       = 1'b0;
`endif

    always_comb begin
        pc_d         = pc_q;
        miss_d       = miss_q;
        push         = 1'b0;
        pop          = 1'b0;
        misalign_set = 1'b0;

        if (redirect) begin
            if (bad_redirect) begin
                misalign_set = 1'b1;
            end else begin
                pc_d   = redirect_addr;
                miss_d = 1'b0;
            end
        end else if (!pc_wait) begin
            miss_d = 1'b0;
            case (pc_src)
                SRC_BRANCH: pc_d = pc_plus4 + branch_off;
                SRC_JUMP:   pc_d = jump_tgt;
                SRC_JAL: begin
                    pc_d = jump_tgt;
                    push = 1'b1;
                end
                SRC_JR: begin
                    if (bad_jr) begin
                        // A refused target is treated like a stall cycle.
                        misalign_set = 1'b1;
                        miss_d       = miss_q;
                    end else begin
                        pc_d = jr_addr;
                        if (jr_is_ra) begin
                            miss_d = ras_empty | (ras_top != jr_addr);
                            pop    = !ras_empty;
                        end
                    end
                end
                default:    pc_d = pc_plus4;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q   <= PC_INIT;
            ptr_q  <= '0;
            cnt_q  <= '0;
            miss_q <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem[i] <= '0;
            end
        end else begin
            pc_q   <= pc_d;
            miss_q <= miss_d;
            if (push) begin
                ptr_q            <= ptr_inc;
                ras_mem[ptr_inc] <= pc_plus4;
                // When the stack is full, the push overwrites the oldest entry and the count stays saturated.
                if (!ras_full) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end else if (pop) begin
                ptr_q <= ptr_dec;
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

`ifdef PC_MISALIGN_CHK_EN
    logic misalign_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            misalign_q <= 1'b0;
        end else if (misalign_set) begin
            misalign_q <= 1'b1;
        end
    end

    assign misalign = misalign_q;
`else
    assign misalign = 1'b0;

    logic unused_misalign;
    assign unused_misalign = misalign_set;
`endif

endmodule
